// File: rtl/zmod_txpll_ctrl.sv
// Power-up, lock-qualification and recovery sequencer for the ZMOD TX PLL.
// Define ZMOD_TXPLL_CTRL_LOSS_CNT_EN to add the loss_cnt lock-loss event counter.
module zmod_txpll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       restart,
  input  logic       locked,
  output logic       pll_pwrdwn,
  output logic       pll_rst,
  output logic       tx_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [2:0] state
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          pwrdwn_q, pllrst_q, txrst_q, ready_q, fault_q;
  logic          timeout;

  assign timeout = (tmr_q == TW'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tmr_d   = tmr_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = S_OFF;
    end else if (restart && state_q != S_OFF) begin
      state_d = S_RESET;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_RESET;
          retry_d = 4'd0;
        end
        S_RESET: begin
          if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = S_WAIT;
          else rcnt_d = rcnt_q + RW'(1);
        end
        S_WAIT, S_STABLE: begin
          // The lock timer is a hard deadline and wins over any lock progress.
          if (timeout) begin
            if (retry_q == 4'(MAX_RETRY)) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_RESET;
              if (retry_q != 4'd15) retry_d = retry_q + 4'd1;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
            if (state_q == S_WAIT) begin
              if (sync2_q) begin
                state_d = S_STABLE;
                scnt_d  = '0;
              end
            end else if (!sync2_q) begin
              state_d = S_WAIT;
            end else if (scnt_q == SW'(STABLE_CYCLES - 1)) begin
              state_d = S_RUN;
              retry_d = 4'd0;
            end else begin
              scnt_d = scnt_q + SW'(1);
            end
          end
        end
        S_RUN: begin
          if (!sync2_q) state_d = S_RESET;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_OFF;
      endcase
    end
    // Any (re-)entry into RESET restarts both the pulse and the lock deadline.
    if (state_d == S_RESET && (state_q != S_RESET || restart)) begin
      rcnt_d = '0;
      tmr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= S_OFF;
      rcnt_q   <= '0;
      tmr_q    <= '0;
      scnt_q   <= '0;
      retry_q  <= 4'd0;
      pwrdwn_q <= 1'b1;
      pllrst_q <= 1'b1;
      txrst_q  <= 1'b1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= locked;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      tmr_q    <= tmr_d;
      scnt_q   <= scnt_d;
      retry_q  <= retry_d;
      pwrdwn_q <= (state_d == S_OFF);
      pllrst_q <= (state_d inside {S_OFF, S_RESET, S_FAULT});
      txrst_q  <= (state_d != S_RUN);
      ready_q  <= (state_d == S_RUN);
      fault_q  <= (state_d == S_FAULT);
    end
  end

`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_inc;

  // RUN only falls back to RESET through a restart or a lock loss.
  assign loss_inc = (state_q == S_RUN) && (state_d == S_RESET) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else if (loss_inc && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign loss_cnt = loss_q;
`endif

  assign pll_pwrdwn = pwrdwn_q;
  assign pll_rst    = pllrst_q;
  assign tx_rst     = txrst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_zmod_txpll_ctrl.sv
// Randomised and directed bench for zmod_txpll_ctrl against a deadline-based reference model.
module tb_zmod_txpll_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int M_OFF = 0, M_RESET = 1, M_WAIT = 2, M_STABLE = 3, M_RUN = 4, M_FAULT = 5;

  logic       clk, rst, enable, restart, locked;
  logic       pll_pwrdwn, pll_rst, tx_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;
`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  zmod_txpll_ctrl #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart), .locked(locked),
    .pll_pwrdwn(pll_pwrdwn), .pll_rst(pll_rst), .tx_rst(tx_rst), .ready(ready),
    .fault(fault), .retry_cnt(retry_cnt),
`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
    .loss_cnt(loss_cnt),
`endif
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: state plus the cycle stamps at which deadlines started.
  int ms, mretry, mloss, cyc, t_rst, t_wait, t_stab;
  bit s1, s2;

  function automatic void m_reset();
    ms = M_OFF; mretry = 0; mloss = 0; cyc = 0;
    t_rst = 0; t_wait = 0; t_stab = 0; s1 = 1'b0; s2 = 1'b0;
  endfunction

  function automatic void m_step();
    bit ls;
    ls = s2; s2 = s1; s1 = locked;
    cyc++;
    if (!enable) ms = M_OFF;
    else if (restart && ms != M_OFF) begin ms = M_RESET; mretry = 0; t_rst = cyc; end
    else begin
      case (ms)
        M_OFF: begin ms = M_RESET; mretry = 0; t_rst = cyc; end
        M_RESET: if (cyc - t_rst >= RST_CYCLES) begin ms = M_WAIT; t_wait = cyc; end
        M_WAIT, M_STABLE: begin
          if (cyc - t_wait >= LOCK_TIMEOUT) begin
            if (mretry >= MAX_RETRY) ms = M_FAULT;
            else begin mretry++; ms = M_RESET; t_rst = cyc; end
          end else if (ms == M_WAIT) begin
            if (ls) begin ms = M_STABLE; t_stab = cyc; end
          end else if (!ls) ms = M_WAIT;
          else if (cyc - t_stab >= STABLE_CYCLES) begin ms = M_RUN; mretry = 0; end
        end
        M_RUN: if (!ls) begin ms = M_RESET; t_rst = cyc; if (mloss < 255) mloss++; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [11:0] m_outs();
    return {3'(ms), ms == M_OFF, (ms == M_OFF || ms == M_RESET || ms == M_FAULT),
            ms != M_RUN, ms == M_RUN, ms == M_FAULT, 4'(mretry)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    @(negedge clk);
    chk("outs", {state, pll_pwrdwn, pll_rst, tx_rst, ready, fault, retry_cnt}, m_outs());
`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
    chk("loss", loss_cnt, mloss);
`endif
  endtask

  initial begin
    int cnt, resets, hold, mode;
    int rvals[4];
    bit saw_stable, rewait;
    rst = 1'b1; enable = 1'b0; restart = 1'b0; locked = 1'b0;
    m_reset();
    #1;
    chk("rst_state", state, 0);
    chk("rst_pwrdwn", pll_pwrdwn, 1);
    chk("rst_txrst", tx_rst, 1);
    step(); step();
    rst = 1'b0;
    step();

    // 1: nominal bring-up
    enable = 1'b1;
    step();
    chk("t1_enter_reset", state, M_RESET);
    cnt = 0;
    do begin step(); cnt++; end while (state == 3'(M_RESET) && cnt < 20);
    chk("t1_pllrst_len", cnt, RST_CYCLES);
    chk("t1_pllrst_low", pll_rst, 0);
    for (int i = 0; i < 10; i++) step();
    locked = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (tx_rst && cnt < 50);
    chk("t1_txrst_lat", cnt, STABLE_CYCLES + 3);
    chk("t1_ready", ready, 1);
    chk("t1_state", state, M_RUN);

    // 2: timeouts then fault, then restart
    enable = 1'b0; locked = 1'b0;
    step();
    enable = 1'b1;
    resets = 0;
    for (int i = 0; i < 300 && !fault; i++) begin
      logic [2:0] prev;
      prev = state;
      step();
      if (state == 3'(M_RESET) && prev != 3'(M_RESET)) begin
        if (resets < 4) rvals[resets] = int'(retry_cnt);
        resets++;
      end
    end
    chk("t2_resets", resets, 3);
    for (int i = 0; i < 3; i++) chk("t2_retry_seq", rvals[i], i);
    chk("t2_fault", fault, 1);
    chk("t2_state", state, M_FAULT);
    chk("t2_retry", retry_cnt, MAX_RETRY);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t2_rs_state", state, M_RESET);
    chk("t2_rs_retry", retry_cnt, 0);
    chk("t2_rs_fault", fault, 0);

    // 3: lock loss in RUN
    locked = 1'b1;
    for (int i = 0; i < 100 && !ready; i++) step();
    chk("t3_ready_pre", ready, 1);
    locked = 1'b0;
    step(); step();
    chk("t3_txrst_2", tx_rst, 0);
    step();
    chk("t3_txrst_3", tx_rst, 1);
    chk("t3_state_3", state, M_RESET);
    for (int i = 0; i < 17; i++) step();
    locked = 1'b1;
    for (int i = 0; i < 100 && !ready; i++) step();
    chk("t3_ready_post", ready, 1);
`ifdef ZMOD_TXPLL_CTRL_LOSS_CNT_EN
    chk("t3_loss_cnt", loss_cnt, 1);
`endif

    // 4: chatter in STABLE
    restart = 1'b1; locked = 1'b0;
    step();
    restart = 1'b0;
    chk("t4_restart", state, M_RESET);
    for (int i = 0; i < 20 && state != 3'(M_WAIT); i++) step();
    chk("t4_wait", state, M_WAIT);
    locked = 1'b1;
    saw_stable = 1'b0; rewait = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); if (state == 3'(M_STABLE)) saw_stable = 1'b1; end
    locked = 1'b0;
    for (int i = 0; i < 2; i++) step();
    locked = 1'b1;
    cnt = 0;
    do begin
      step(); cnt++;
      if (state == 3'(M_STABLE)) saw_stable = 1'b1;
      if (saw_stable && state == 3'(M_WAIT)) rewait = 1'b1;
    end while (!ready && cnt < 60);
    chk("t4_rewait", rewait, 1);
    chk("t4_lat", cnt, STABLE_CYCLES + 3);
    chk("t4_ready", ready, 1);
    chk("t4_retry", retry_cnt, 0);

    // 5: disable beats restart
    chk("t5_pre_run", state, M_RUN);
    enable = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t5_state", state, M_OFF);
    chk("t5_pwrdwn", pll_pwrdwn, 1);
    chk("t5_txrst", tx_rst, 1);

    // 6: async reset in WAIT_LOCK with a nonzero retry count
    enable = 1'b1; locked = 1'b0;
    for (int i = 0; i < 100 && !(retry_cnt == 4'd1 && state == 3'(M_WAIT)); i++) step();
    chk("t6_pre_retry", retry_cnt, 1);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t6_state", state, 0);
    chk("t6_pwrdwn", pll_pwrdwn, 1);
    chk("t6_pllrst", pll_rst, 1);
    chk("t6_txrst", tx_rst, 1);
    chk("t6_ready", ready, 0);
    chk("t6_fault", fault, 0);
    chk("t6_retry", retry_cnt, 0);
    m_reset();
    step(); step();
    rst = 1'b0;

    // Randomised: healthy, chattering and dead lock phases
    hold = 0;
    for (int seg = 0; seg < 9; seg++) begin
      mode = seg % 3;
      for (int c = 0; c < 400; c++) begin
        if (hold <= 0) begin
          case (mode)
            0: begin locked = ($urandom_range(0, 7) != 0); hold = int'($urandom_range(10, 60)); end
            1: begin locked = 1'($urandom_range(0, 1)); hold = int'($urandom_range(1, 12)); end
            default: begin locked = 1'b0; hold = 400; end
          endcase
        end
        hold--;
        restart = ($urandom_range(0, 149) == 0);
        if (enable) enable = ($urandom_range(0, 299) != 0);
        else enable = ($urandom_range(0, 9) == 0);
        step();
      end
      hold = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
